key_conditioner: RTL and testbench

- Input conditioning stage between the raw board pushbuttons (KEY) and the demo/user DUT's KEY input.
- Per key: synchronises the raw asynchronous level, debounces it, and produces a clean active-low level the DUT consumes directly.
- Also produces one-cycle press/release strobes and an auto-repeat strobe for UI-style logic (counters, HEX menus).

---
 rtl/key_conditioner.sv | 128 ++++++++++++
 tb/tb_key_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key two-flop synchroniser, debouncer, press/release
// strobes and an auto-repeat strobe generator. All outputs come straight from flops.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_KEYS-1:0] KEY_RAW,
    output logic [NUM_KEYS-1:0] KEY_CLEAN,
    output logic [NUM_KEYS-1:0] KEY_PRESS,
    output logic [NUM_KEYS-1:0] KEY_RELEASE,
    output logic [NUM_KEYS-1:0] KEY_REPEAT,
    output logic [NUM_KEYS-1:0] KEY_HELD
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_RPT,
        S_HOLD
    } rpt_state_t;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic             r_sync1, r_sync2;
        logic             r_clean, r_held, r_press, r_release, r_repeat;
        logic [CNT_W-1:0] r_cnt;
        logic [TMR_W-1:0] r_tmr, w_tmr_next;
        rpt_state_t       r_state, w_state_next;
        logic             w_flip, w_press_evt, w_release_evt, w_repeat_next;

        // The clean level flips on the D-th consecutive sample that disagrees with it.
        assign w_flip        = (r_sync2 != r_clean) && (r_cnt == CNT_LAST);
        assign w_press_evt   = w_flip && !r_sync2;
        assign w_release_evt = w_flip && r_sync2;

        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_sync1   <= 1'b1;
                r_sync2   <= 1'b1;
                r_clean   <= 1'b1;
                r_held    <= 1'b0;
                r_cnt     <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_sync1   <= KEY_RAW[g];
                r_sync2   <= r_sync1;
                r_press   <= w_press_evt;
                r_release <= w_release_evt;
                if (r_sync2 == r_clean) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_clean <= r_sync2;
                    r_held  <= ~r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_state  <= S_IDLE;
                r_tmr    <= '0;
                r_repeat <= 1'b0;
            end else begin
                r_state  <= w_state_next;
                r_tmr    <= w_tmr_next;
                r_repeat <= w_repeat_next;
            end
        end

        // NOTE: every comb output gets a default first so no path can infer a latch.
        always_comb begin
            w_state_next = r_state;
            unique case (r_state)
                S_IDLE:  if (w_press_evt) w_state_next = (REPEAT_DELAY == 0) ? S_HOLD : S_DELAY;
                S_DELAY: if (w_release_evt) w_state_next = S_IDLE;
                         else if (r_tmr == DELAY_LAST) w_state_next = S_RPT;
                S_RPT:   if (w_release_evt) w_state_next = S_IDLE;
                S_HOLD:  if (w_release_evt) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end

        // A release always suppresses a repeat strobe due on the same edge.
        always_comb begin
            w_tmr_next    = '0;
            w_repeat_next = 1'b0;
            unique case (r_state)
                S_IDLE: w_repeat_next = w_press_evt;
                S_DELAY: begin
                    if (!w_release_evt) begin
                        if (r_tmr == DELAY_LAST) w_repeat_next = 1'b1;
                        else                     w_tmr_next    = r_tmr + 1'b1;
                    end
                end
                S_RPT: begin
                    if (!w_release_evt) begin
                        if (r_tmr == RATE_LAST) w_repeat_next = 1'b1;
                        else                    w_tmr_next    = r_tmr + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        assign KEY_CLEAN[g]   = r_clean;
        assign KEY_HELD[g]    = r_held;
        assign KEY_PRESS[g]   = r_press;
        assign KEY_RELEASE[g] = r_release;
        assign KEY_REPEAT[g]  = r_repeat;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key activity,
// compared every cycle against a sample-window / press-time reference model.
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int D  = 16;
    localparam int RD = 64;
    localparam int RR = 16;

    logic          CLK;
    logic          RST;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_clean, key_press, key_release, key_repeat, key_held;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .KEY_RAW    (key_raw),
        .KEY_CLEAN  (key_clean),
        .KEY_PRESS  (key_press),
        .KEY_RELEASE(key_release),
        .KEY_REPEAT (key_repeat),
        .KEY_HELD   (key_held)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: raw seen at an edge reaches the debouncer two edges later;
    // the clean level flips when the last D debouncer samples all disagree with it.
    logic [NK-1:0] m_d1, m_d2, m_clean, m_press, m_release, m_repeat;
    logic [NK-1:0] m_win[$];
    int            press_edge[NK];

    int obs_press[NK], obs_release[NK], obs_repeat[NK];

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = '1;
        m_d2 = '1;
        m_clean = '1;
        m_press = '0;
        m_release = '0;
        m_repeat = '0;
        m_win.delete();
        for (int k = 0; k < NK; k++) press_edge[k] = 0;
    endtask

    task automatic model_edge();
        logic [NK-1:0] s;
        bit            all_diff;
        int            e;
        s    = m_d2;
        m_d2 = m_d1;
        m_d1 = key_raw;
        m_win.push_back(s);
        if (m_win.size() > D) void'(m_win.pop_front());
        m_press = '0;
        m_release = '0;
        m_repeat = '0;
        for (int k = 0; k < NK; k++) begin
            all_diff = (m_win.size() == D);
            foreach (m_win[i]) if (m_win[i][k] == m_clean[k]) all_diff = 0;
            if (all_diff) begin
                m_clean[k] = ~m_clean[k];
                if (!m_clean[k]) begin
                    m_press[k]    = 1'b1;
                    press_edge[k] = cyc;
                end else begin
                    m_release[k] = 1'b1;
                end
            end
            if (!m_clean[k]) begin
                e = cyc - press_edge[k];
                if (e == 0 || (RD > 0 && e >= RD && (e - RD) % RR == 0)) m_repeat[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check("clean", key_clean, m_clean);
        check("held", key_held, ~m_clean);
        check("press", key_press, m_press);
        check("release", key_release, m_release);
        check("repeat", key_repeat, m_repeat);
    endtask

    task automatic clear_obs();
        for (int k = 0; k < NK; k++) begin
            obs_press[k] = 0;
            obs_release[k] = 0;
            obs_repeat[k] = 0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        if (!RST) model_edge();
        #1;
        check_all();
        for (int k = 0; k < NK; k++) begin
            obs_press[k]   += int'(key_press[k]);
            obs_release[k] += int'(key_release[k]);
            obs_repeat[k]  += int'(key_repeat[k]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RST = 1'b1;
        key_raw = '0;
        model_reset();
        clear_obs();
        #1;
        check_all();
        check("rst_clean", key_clean, 4'b1111);
        run(3);

        // All keys held through reset: nothing until the debounce completes.
        RST = 1'b0;
        run(17);
        check("rst_hold_clean", key_clean, 4'b1111);
        step();
        check("rst_first_press", key_press, 4'b1111);
        key_raw = '1;
        run(24);

        // Clean press and release on key 0.
        key_raw = 4'b1110;
        run(17);
        check("k0_before", key_clean, 4'b1111);
        step();
        check("k0_clean", key_clean, 4'b1110);
        check("k0_press", key_press, 4'b0001);
        check("k0_repeat", key_repeat, 4'b0001);
        step();
        check("k0_press_1cyc", key_press, 4'b0000);
        key_raw = 4'b1111;
        run(17);
        step();
        check("k0_release", key_release, 4'b0001);
        run(5);

        // Bounce on key 1 never debounces.
        clear_obs();
        key_raw = 4'b1101; run(10);
        key_raw = 4'b1111; run(3);
        key_raw = 4'b1101; run(10);
        key_raw = 4'b1111; run(30);
        check("k1_bounce_strobes", 4'(obs_press[1] + obs_release[1] + obs_repeat[1]), 4'd0);

        // Auto-repeat on key 2: first repeat 64 after press, then every 16.
        key_raw = 4'b1011;
        run(18);
        check("k2_press", key_press, 4'b0100);
        clear_obs();
        run(192);
        check("k2_auto_repeats", 4'(obs_repeat[2]), 4'd9);
        check("k2_single_press", 4'(obs_press[2]), 4'd0);
        run(8);
        key_raw = 4'b1111;
        run(24);

        // Release debounced on the edge the first repeat would fire.
        key_raw = 4'b1011;
        run(18);
        check("rw_press", key_press, 4'b0100);
        run(46);
        key_raw = 4'b1111;
        run(17);
        step();
        check("rw_release", key_release, 4'b0100);
        check("rw_no_repeat", key_repeat, 4'b0000);
        run(5);
        key_raw = 4'b1011;
        run(17);
        step();
        check("rw_idle_repress", key_repeat, 4'b0100);
        key_raw = 4'b1111;
        run(24);

        // Keys 0 and 3 together, then reset while held.
        key_raw = 4'b0110;
        run(18);
        check("mk_press", key_press, 4'b1001);
        check("mk_repeat", key_repeat, 4'b1001);
        run(10);
        clear_obs();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_all();
        check("mk_rst_clean", key_clean, 4'b1111);
        check("mk_rst_held", key_held, 4'b0000);
        run(3);
        RST = 1'b0;
        run(17);
        check("mk_no_release", 4'(obs_release[0] + obs_release[3]), 4'd0);
        check("mk_wait_clean", key_clean, 4'b1111);
        step();
        check("mk_fresh_press", key_press, 4'b1001);
        key_raw = 4'b1111;
        run(24);

        // Random key activity with a reset pulse in the middle.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 23) == 0) key_raw[k] = ~key_raw[k];
            if (i == 1500) begin
                RST = 1'b1;
                model_reset();
                #1;
                check_all();
            end
            if (i == 1504) RST = 1'b0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
